pll_reset_ctrl: RTL and testbench
=================================

# pll_reset_ctrl

Reset and lock sequencer for the video PLL. It drives the PLL reset input, watches the PLL's asynchronous `locked` output, and holds the 65 MHz pixel domain in reset until lock has been stable for a programmable time. It sits beside the PLL on the free-running 50 MHz reference clock. It reports lock loss, retries a PLL that fails to lock, and gives up after a bounded number of attempts.

## Interface
Parameters:
- `RST_CYCLES`, default 50: refclk cycles `pll_rst` is held high per reset attempt (1 us). Must be ≥1.
- `LOCK_TIMEOUT`, default 50000: refclk cycles allowed in S_WAIT for lock before retry (1 ms). Must be ≥1.
- `STABLE_CYCLES`, default 1000: consecutive synchronized-locked cycles required before `clk_ready`. Must be ≥1.
- `MAX_RETRIES`, default 7: failed attempts tolerated. Total attempts = MAX_RETRIES+1.

Ports:
- `refclk` in 1: 50 MHz free-running clock; the only clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `pll_locked` in 1: PLL lock flag, asynchronous to refclk.
- `pll_rst` out 1: drives the PLL reset, active-high.
- `clk_ready` out 1: high while the PLL output is usable. Downstream synchronizes it into the 65 MHz domain as that domain's reset release.
- `lock_lost` out 1: one-cycle pulse when lock drops in S_RUN.
- `fail` out 1: sticky. The retry budget is exhausted.
- `relock_count` out 8: count of lock losses in S_RUN, saturating at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (reset to 0) to give `locked_s`. All decisions use `locked_s` only.
- State machine, with all outputs registered:
  - **S_RST**
    - `pll_rst`=1.
    - Counter runs from 0. After RST_CYCLES cycles, go to S_WAIT.
    - `locked_s` is ignored.
  - **S_WAIT**
    - `pll_rst`=0. The timeout counter runs from 0.
    - If `locked_s`=1, go to S_STABLE.
    - Otherwise, when the timeout counter reaches LOCK_TIMEOUT, a retry event occurs.
  - **S_STABLE**
    - The stable counter runs from 0 while `locked_s`=1.
    - When it reaches STABLE_CYCLES, go to S_RUN.
    - If `locked_s`=0 at any point, a retry event occurs.
  - **S_RUN**
    - `clk_ready`=1. The retry counter is cleared on entry.
    - If `locked_s`=0: go to S_RST, pulse `lock_lost`, and increment `relock_count` (saturating). This does not consume retry budget.
  - **S_FAIL**
    - `pll_rst`=1, `fail`=1, `clk_ready`=0. Terminal until `rst_n`.
- Retry event:
  - If retry_cnt == MAX_RETRIES, go to S_FAIL.
  - Otherwise retry_cnt++ and go to S_RST.
- Counter widths: $clog2(param+1). Counters never wrap; each is cleared on state entry.
- `clk_ready` is 1 only in S_RUN. `pll_rst` is 1 only in S_RST and S_FAIL.

## Timing
- While `rst_n`=0, asynchronously:
  - State is S_RST.
  - `pll_rst`=1, `clk_ready`=0, `lock_lost`=0, `fail`=0, `relock_count`=0.
  - All counters and synchronizer flops are 0.
- After `rst_n` rises, `pll_rst` stays high for exactly RST_CYCLES rising edges. It falls on the edge that enters S_WAIT.
- Lock acquisition latency: with `pll_locked` sampled high at edge k, `locked_s`=1 from edge k+1. The state reaches S_STABLE at edge k+2, and `clk_ready` rises at edge k+2+STABLE_CYCLES.
- Lock-loss latency:
  - With `pll_locked` sampled low at edge k in S_RUN, `clk_ready` falls and `lock_lost` is high for the cycle after edge k+2.
  - `pll_rst` rises at edge k+2.
- Timeout: S_WAIT lasts exactly LOCK_TIMEOUT cycles when no lock arrives. `pll_rst` rises on the next edge.
- `rst_n` asserted in any state, including S_FAIL, returns everything to reset values immediately. `relock_count` is cleared.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.

- **Nominal lock:** release `rst_n`, raise `pll_locked` 10 cycles after `pll_rst` falls -> `pll_rst` high exactly 4 cycles; `clk_ready` rises 10 edges after `pll_locked` is first sampled high; `fail`=0, `relock_count`=0.
- **Never locks:** hold `pll_locked`=0 -> 3 `pll_rst` pulses of 4 cycles, each followed by 20 low cycles; then `pll_rst`=1 permanently, `fail`=1, `clk_ready` never rises.
- **Unstable lock:** `pll_locked` high for 5 cycles then low, on every attempt -> no `clk_ready`; after the third drop, `fail`=1. Then assert `rst_n` -> `fail`=0, `pll_rst`=1.
- **Lock loss in RUN:** reach S_RUN, drop `pll_locked` -> `clk_ready` falls and a single 1-cycle `lock_lost` pulse occurs 2 edges after the drop; `relock_count`=1; resequence completes normally. Repeat 300 times -> `relock_count` saturates at 255.
- **Ignored lock in S_RST:** `pll_locked`=1 throughout reset -> `pll_rst` still high exactly 4 cycles; `clk_ready` rises at S_WAIT entry + 1 + 8.
- **Mid-operation reset:** assert `rst_n`=0 during S_STABLE and during S_RUN -> `pll_rst`=1, `clk_ready`=0, and counters zero, asynchronously before the next edge.

Source files
------------

// File: rtl/pll_reset_ctrl_if.sv
// PLL reset/lock sequencer signal bundle.
// master: controller side; slave: PLL/downstream side.
interface pll_reset_ctrl_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       clk_ready;
  logic       lock_lost;
  logic       fail;
  logic [7:0] relock_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output clk_ready,
    output lock_lost,
    output fail,
    output relock_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  clk_ready,
    input  lock_lost,
    input  fail,
    input  relock_count
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset and lock sequencer on refclk.
// Ports: refclk, rst_n, io (pll_locked in; pll_rst, clk_ready, lock_lost, fail, relock_count out).
module pll_reset_ctrl #(
  parameter int RST_CYCLES    = 50,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1000,
  parameter int MAX_RETRIES   = 7
) (
  input  logic refclk,
  input  logic rst_n,
  pll_reset_ctrl_if.master io
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int WW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int YW = (MAX_RETRIES > 0) ?
                      $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [YW-1:0] retry_q, retry_d;
  logic [7:0]    relock_d;
  logic          lost_d;
  logic          retry_ev;
  logic          sync1, locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= io.pll_locked;
      locked_s <= sync1;
    end
  end

  // Counters default to zero so each one is
  // cleared whenever its state is left/entered.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = '0;
    wait_cnt_d = '0;
    stab_cnt_d = '0;
    retry_d    = retry_q;
    relock_d   = io.relock_count;
    lost_d     = 1'b0;
    retry_ev   = 1'b0;
    unique case (state_q)
      S_RST: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1))
          state_d = S_WAIT;
        else
          rst_cnt_d = rst_cnt_q + RW'(1);
      end
      S_WAIT: begin
        if (locked_s)
          state_d = S_STABLE;
        else if (wait_cnt_q == WW'(LOCK_TIMEOUT - 1))
          retry_ev = 1'b1;
        else
          wait_cnt_d = wait_cnt_q + WW'(1);
      end
      S_STABLE: begin
        if (!locked_s)
          retry_ev = 1'b1;
        else if (stab_cnt_q == SW'(STABLE_CYCLES - 1))
          state_d = S_RUN;
        else
          stab_cnt_d = stab_cnt_q + SW'(1);
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_RST;
          lost_d  = 1'b1;
          if (io.relock_count != 8'hff)
            relock_d = io.relock_count + 8'd1;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
    if (retry_ev) begin
      if (retry_q == YW'(MAX_RETRIES)) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + YW'(1);
        state_d = S_RST;
      end
    end
    // A successful lock refunds the whole budget.
    if (state_d == S_RUN && state_q != S_RUN)
      retry_d = '0;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_RST;
      rst_cnt_q       <= '0;
      wait_cnt_q      <= '0;
      stab_cnt_q      <= '0;
      retry_q         <= '0;
      io.pll_rst      <= 1'b1;
      io.clk_ready    <= 1'b0;
      io.lock_lost    <= 1'b0;
      io.fail         <= 1'b0;
      io.relock_count <= 8'd0;
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      stab_cnt_q      <= stab_cnt_d;
      retry_q         <= retry_d;
      io.pll_rst      <= (state_d == S_RST) ||
                         (state_d == S_FAIL);
      io.clk_ready    <= (state_d == S_RUN);
      io.lock_lost    <= lost_d;
      io.fail         <= (state_d == S_FAIL);
      io.relock_count <= relock_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl.
// Expectations are timed from reset release and checked at negedge.
module tb_pll_reset_ctrl;
  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int PR   = 0;
  localparam int CR   = 1;
  localparam int LL   = 2;
  localparam int FL   = 3;
  localparam int RCNT = 4;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;

  pll_reset_ctrl_if io();

  pll_reset_ctrl #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #10 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    int    sig;
    int    val;
    string nm;
  } exp_t;

  typedef struct {
    bit pre;
    int dly;
    int ready;
    int retry;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic int peek(int s);
    case (s)
      PR:      return int'(io.pll_rst);
      CR:      return int'(io.clk_ready);
      LL:      return int'(io.lock_lost);
      FL:      return int'(io.fail);
      default: return int'(io.relock_count);
    endcase
  endfunction

  task automatic check(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               nm, cyc, got, exp);
    end
  endtask

  task automatic push(int at, int sig, int val, string nm);
    exp_t e;
    int   idx;
    e.at  = at;
    e.sig = sig;
    e.val = val;
    e.nm  = nm;
    idx   = sb.size();
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at > at) idx = i;
    sb.insert(idx, e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge refclk);
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed cycle %0d", e.nm, e.at);
      end else begin
        check(e.nm, peek(e.sig), e.val);
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 2000) begin
      tick();
      g++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic reset_release(input logic lk, output int r);
    tick();
    rst_n = 1'b0;
    io.pll_locked = lk;
    tick();
    tick();
    rst_n = 1'b1;
    r = cyc;
  endtask

  task automatic rst_now(string nm);
    rst_n = 1'b0;
    #1;
    check({nm, "_pll_rst"}, peek(PR), 1);
    check({nm, "_clk_ready"}, peek(CR), 0);
    check({nm, "_lock_lost"}, peek(LL), 0);
    check({nm, "_fail"}, peek(FL), 0);
    check({nm, "_relock"}, peek(RCNT), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   r;
    int   w;
    int   d;
    int   s;

    tbl[0] = '{1'b0, 10, 21, 0};
    tbl[1] = '{1'b0, 0, 11, 0};
    tbl[2] = '{1'b0, 17, 28, 0};
    tbl[3] = '{1'b0, 18, 33, 20};
    tbl[4] = '{1'b1, -1, 9, 0};

    io.pll_locked = 1'b0;
    tick();
    check("rst_pll_rst", peek(PR), 1);
    check("rst_clk_ready", peek(CR), 0);
    check("rst_lock_lost", peek(LL), 0);
    check("rst_fail", peek(FL), 0);
    check("rst_relock", peek(RCNT), 0);

    foreach (tbl[i]) begin
      reset_release(tbl[i].pre, r);
      w = r + RC;
      push(r + 1, PR, 1, "v_rst_hold");
      push(w - 1, PR, 1, "v_rst_last");
      push(w, PR, 0, "v_rst_fall");
      push(w + tbl[i].ready - 1, CR, 0, "v_ready_pre");
      push(w + tbl[i].ready, CR, 1, "v_ready");
      push(w + tbl[i].ready, FL, 0, "v_fail");
      push(w + tbl[i].ready, RCNT, 0, "v_relock");
      if (tbl[i].retry > 0) begin
        s = w + tbl[i].retry;
        push(s - 1, PR, 0, "v_retry_pre");
        push(s, PR, 1, "v_retry_rise");
        push(s + RC - 1, PR, 1, "v_retry_hold");
        push(s + RC, PR, 0, "v_retry_fall");
      end
      while (cyc < w + tbl[i].ready + 1) begin
        tick();
        if (!tbl[i].pre && cyc == w + tbl[i].dly)
          io.pll_locked = 1'b1;
      end
      drain();
    end

    reset_release(1'b1, r);
    w = r + RC;
    while (cyc < w + 4) tick();
    rst_now("mid_stable");
    tick();
    rst_n = 1'b1;
    r = cyc;
    w = r + RC;
    push(w - 1, PR, 1, "ms_rst_last");
    push(w, PR, 0, "ms_rst_fall");
    push(w + 8, CR, 0, "ms_ready_pre");
    push(w + 9, CR, 1, "ms_ready");
    drain();

    reset_release(1'b0, r);
    for (int j = 0; j <= MR; j++) begin
      s = r + (RC + LT) * j;
      if (j > 0) begin
        push(s - 1, PR, 0, "nl_rise_pre");
        push(s, PR, 1, "nl_rise");
      end
      push(s + RC - 1, PR, 1, "nl_hold");
      push(s + RC, PR, 0, "nl_fall");
      push(s + RC + LT - 1, PR, 0, "nl_wait_end");
      push(s + 12, CR, 0, "nl_ready");
    end
    s = r + (RC + LT) * (MR + 1);
    push(s - 1, FL, 0, "nl_fail_pre");
    push(s, FL, 1, "nl_fail");
    push(s, PR, 1, "nl_fail_rst");
    push(s + 18, PR, 1, "nl_fail_rst_late");
    push(s + 18, FL, 1, "nl_fail_late");
    push(s + 18, CR, 0, "nl_ready_late");
    while (cyc < s + 19) tick();
    drain();

    reset_release(1'b0, r);
    for (int j = 0; j <= MR; j++) begin
      w = r + RC + 14 * j;
      push(w + 9, CR, 0, "ul_ready");
      push(w + 9, PR, 0, "ul_rst_pre");
      push(w + 10, PR, 1, "ul_rst_rise");
    end
    s = r + RC + 14 * MR + 10;
    push(s - 1, FL, 0, "ul_fail_pre");
    push(s, FL, 1, "ul_fail");
    while (cyc < s + 8) begin
      tick();
      for (int j = 0; j <= MR; j++) begin
        w = r + RC + 14 * j;
        if (cyc == w + 2) io.pll_locked = 1'b1;
        if (cyc == w + 7) io.pll_locked = 1'b0;
      end
    end
    drain();
    rst_now("ul_reset");

    reset_release(1'b1, r);
    push(r + RC + 9, CR, 1, "lr_ready");
    while (cyc < r + RC + 10) tick();
    for (int i = 0; i < 300; i++) begin
      d = cyc;
      push(d + 2, CR, 1, "lr_ready_hold");
      push(d + 3, CR, 0, "lr_ready_fall");
      push(d + 2, LL, 0, "lr_lost_pre");
      push(d + 3, LL, 1, "lr_lost");
      push(d + 4, LL, 0, "lr_lost_post");
      push(d + 3, PR, 1, "lr_rst_rise");
      push(d + 2, RCNT, (i > 255) ? 255 : i, "lr_cnt_pre");
      push(d + 3, RCNT, (i + 1 > 255) ? 255 : i + 1, "lr_cnt");
      push(d + 15, CR, 0, "lr_reready_pre");
      push(d + 16, CR, 1, "lr_reready");
      push(d + 16, FL, 0, "lr_fail");
      if (i < 3) begin
        push(d + 6, PR, 1, "lr_rst_last");
        push(d + 7, PR, 0, "lr_rst_fall");
      end
      io.pll_locked = 1'b0;
      while (cyc < d + 3) tick();
      io.pll_locked = 1'b1;
      while (cyc < d + 17) tick();
    end
    drain();
    check("run_relock_sat", peek(RCNT), 255);
    rst_now("mid_run");
    tick();
    rst_n = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
